// File: rtl/sal_pkg.sv
// sal_pkg: shared widths, bank FSM states and bank-controller/scheduler handshake types.
package sal_pkg;
    localparam int DRAM_BA_WIDTH = 3;
    localparam int DRAM_RA_WIDTH = 14;
    localparam int DRAM_CA_WIDTH = 10;
    localparam int AXI_ID_WIDTH  = 4;
    localparam int AXI_LEN_WIDTH = 8;
    localparam int T_RCD_WIDTH   = 4;
    localparam int T_RAS_WIDTH   = 6;
    localparam int T_RTP_WIDTH   = 4;
    localparam int T_WR_WIDTH    = 6;
    localparam int T_RP_WIDTH    = 4;
    localparam int T_RFC_WIDTH   = 8;

    typedef enum logic [2:0] {CLOSED, ACTIVATING, OPEN, PRECHARGING, REFRESHING} bk_state_e;

    typedef struct packed {
        logic                     act_req;
        logic                     rd_req;
        logic                     wr_req;
        logic                     pre_req;
        logic                     ref_req;
        logic [DRAM_BA_WIDTH-1:0] ba;
        logic [DRAM_RA_WIDTH-1:0] ra;
        logic [DRAM_CA_WIDTH-1:0] ca;
        logic [AXI_ID_WIDTH-1:0]  id;
        logic [AXI_LEN_WIDTH-1:0] len;
    } bk_req_t;

    typedef struct packed {
        logic act_gnt;
        logic rd_gnt;
        logic wr_gnt;
        logic pre_gnt;
        logic ref_gnt;
    } bk_gnt_t;
endpackage

// File: rtl/sal_timing_if.sv
// TIMING_IF: per-channel DRAM timing parameters, each stored as cycles minus one.
interface TIMING_IF;
    import sal_pkg::*;
    logic [T_RCD_WIDTH-1:0] t_rcd_m1;
    logic [T_RAS_WIDTH-1:0] t_ras_m1;
    logic [T_RTP_WIDTH-1:0] t_rtp_m1;
    logic [T_WR_WIDTH-1:0]  t_wr_m1;
    logic [T_RP_WIDTH-1:0]  t_rp_m1;
    logic [T_RFC_WIDTH-1:0] t_rfc_m1;
    modport MON(input t_rcd_m1, t_ras_m1, t_rtp_m1, t_wr_m1, t_rp_m1, t_rfc_m1);
endinterface

// File: rtl/sal_dn_cnt.sv
// sal_dn_cnt: loadable down-counter that saturates at zero.
module sal_dn_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] val,
    output logic         is_zero
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (ld)
            cnt_q <= val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign is_zero = cnt_q == '0;
endmodule

// File: rtl/sal_bk_ctrl.sv
// sal_bk_ctrl: per-bank DRAM controller raising one act/rd/wr/pre/ref request toward the scheduler.
module sal_bk_ctrl
    import sal_pkg::*;
#(
    parameter int BK_ID = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    TIMING_IF.MON                    timing_if,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_wr,
    input  logic [DRAM_RA_WIDTH-1:0] cmd_ra,
    input  logic [DRAM_CA_WIDTH-1:0] cmd_ca,
    input  logic [AXI_ID_WIDTH-1:0]  cmd_id,
    input  logic [AXI_LEN_WIDTH-1:0] cmd_len,
    input  logic                     ref_req_i,
    output logic                     ref_done_o,
    output bk_req_t                  bk_req,
    input  bk_gnt_t                  bk_gnt
);
    bk_state_e                state_q, state_d, st;
    logic                     pend_q, pend_wr_q;
    logic [DRAM_RA_WIDTH-1:0] pend_ra_q, open_row_q;
    logic [DRAM_CA_WIDTH-1:0] pend_ca_q;
    logic [AXI_ID_WIDTH-1:0]  pend_id_q;
    logic [AXI_LEN_WIDTH-1:0] pend_len_q;
    logic                     rcd_z, ras_z, rtp_z, wr_z, rp_z, rfc_z;
    logic                     ref_pend, hit, want_pre;
    bk_gnt_t                  g;

    // A wait state whose timer has expired behaves as its successor this cycle,
    // so the follow-on request appears exactly tRCD/tRP/tRFC cycles after the grant.
    assign ref_done_o = state_q == REFRESHING && rfc_z;
    assign st = (state_q == ACTIVATING && rcd_z) ? OPEN :
                ((state_q == PRECHARGING && rp_z) || ref_done_o) ? CLOSED : state_q;
    assign ref_pend  = ref_req_i & ~ref_done_o;
    assign hit       = pend_q && pend_ra_q == open_row_q;
    assign want_pre  = st == OPEN && (ref_pend || (pend_q && !hit)) && ras_z && rtp_z && wr_z;
    assign cmd_ready = ~pend_q;

    always_comb begin
        bk_req         = '0;
        bk_req.ba      = DRAM_BA_WIDTH'(BK_ID);
        bk_req.ra      = want_pre ? open_row_q : pend_ra_q;
        bk_req.ca      = pend_ca_q;
        bk_req.id      = pend_id_q;
        bk_req.len     = pend_len_q;
        bk_req.ref_req = st == CLOSED && ref_pend;
        bk_req.act_req = st == CLOSED && !ref_pend && pend_q;
        bk_req.rd_req  = st == OPEN && !ref_pend && hit && !pend_wr_q;
        bk_req.wr_req  = st == OPEN && !ref_pend && hit && pend_wr_q;
        bk_req.pre_req = want_pre;
    end

    assign g = bk_gnt & {bk_req.act_req, bk_req.rd_req, bk_req.wr_req, bk_req.pre_req, bk_req.ref_req};

    always_comb begin
        state_d = st;
        state_d = g.ref_gnt ? REFRESHING :
                  g.act_gnt ? ACTIVATING :
                  g.pre_gnt ? PRECHARGING : st;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLOSED;
            pend_q     <= 1'b0;
            pend_wr_q  <= 1'b0;
            pend_ra_q  <= '0;
            pend_ca_q  <= '0;
            pend_id_q  <= '0;
            pend_len_q <= '0;
            open_row_q <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_valid && cmd_ready) begin
                pend_q     <= 1'b1;
                pend_wr_q  <= cmd_wr;
                pend_ra_q  <= cmd_ra;
                pend_ca_q  <= cmd_ca;
                pend_id_q  <= cmd_id;
                pend_len_q <= cmd_len;
            end else if (g.rd_gnt || g.wr_gnt) begin
                pend_q <= 1'b0;
            end
            if (g.act_gnt)
                open_row_q <= pend_ra_q;
        end
    end

    sal_dn_cnt #(.W(T_RCD_WIDTH)) u_rcd (.clk, .rst_n, .ld(g.act_gnt), .val(timing_if.t_rcd_m1), .is_zero(rcd_z));
    sal_dn_cnt #(.W(T_RAS_WIDTH)) u_ras (.clk, .rst_n, .ld(g.act_gnt), .val(timing_if.t_ras_m1), .is_zero(ras_z));
    sal_dn_cnt #(.W(T_RTP_WIDTH)) u_rtp (.clk, .rst_n, .ld(g.rd_gnt),  .val(timing_if.t_rtp_m1), .is_zero(rtp_z));
    sal_dn_cnt #(.W(T_WR_WIDTH))  u_wr  (.clk, .rst_n, .ld(g.wr_gnt),  .val(timing_if.t_wr_m1),  .is_zero(wr_z));
    sal_dn_cnt #(.W(T_RP_WIDTH))  u_rp  (.clk, .rst_n, .ld(g.pre_gnt), .val(timing_if.t_rp_m1),  .is_zero(rp_z));
    sal_dn_cnt #(.W(T_RFC_WIDTH)) u_rfc (.clk, .rst_n, .ld(g.ref_gnt), .val(timing_if.t_rfc_m1), .is_zero(rfc_z));
endmodule

// File: tb/tb_sal_bk_ctrl.sv
// tb_sal_bk_ctrl: scoreboard bench; a command-timeline model predicts every granted command and ref_done.
module tb_sal_bk_ctrl;
    import sal_pkg::*;

    localparam int K_ACT = 0, K_RD = 1, K_WR = 2, K_PRE = 3, K_REF = 4, K_DONE = 5;
    localparam int BK = 2;

    typedef struct {
        int kind;
        int cyc;
        int ra;
        int ca;
        int id;
        int len;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [DRAM_RA_WIDTH-1:0] cmd_ra = '0;
    logic [DRAM_CA_WIDTH-1:0] cmd_ca = '0;
    logic [AXI_ID_WIDTH-1:0]  cmd_id = '0;
    logic [AXI_LEN_WIDTH-1:0] cmd_len = '0;
    logic                     ref_req_i = 1'b0, ref_done_o;
    bk_req_t                  bk_req, snap;
    bk_gnt_t                  bk_gnt;
    logic [4:0]               req_bits;
    logic                     hold;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int hold_lo = -10, hold_hi = -10;
    exp_t q[$];

    // model state: command timeline of one bank
    bit m_open;
    int m_row, col_ok, pre_ok, act_ok;
    int t_rcd, t_ras, t_rtp, t_wr, t_rp, t_rfc;

    TIMING_IF tif();

    sal_bk_ctrl #(.BK_ID(BK)) dut (
        .clk(clk), .rst_n(rst_n), .timing_if(tif),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_ra(cmd_ra), .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .ref_req_i(ref_req_i), .ref_done_o(ref_done_o),
        .bk_req(bk_req), .bk_gnt(bk_gnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign req_bits = {bk_req.act_req, bk_req.rd_req, bk_req.wr_req, bk_req.pre_req, bk_req.ref_req};
    assign hold     = cyc >= hold_lo && cyc <= hold_hi;
    assign bk_gnt   = hold ? '0 : req_bits;

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1);
    end

    function automatic int max2(int a, int b);
        return a > b ? a : b;
    endfunction

    function automatic int gate(int t);
        return (t >= hold_lo && t <= hold_hi) ? hold_hi + 1 : t;
    endfunction

    task automatic push(int kind, int c, int ra, int ca, int id, int len);
        exp_t e;
        e.kind = kind; e.cyc = c; e.ra = ra; e.ca = ca; e.id = id; e.len = len;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_open = 0; m_row = 0; col_ok = 0; pre_ok = 0; act_ok = 0;
    endtask

    task automatic model_access(int now, bit wr, int ra, int ca, int id, int len);
        int t;
        if (m_open && m_row != ra) begin
            t = gate(max2(now, pre_ok));
            push(K_PRE, t, m_row, 0, 0, 0);
            act_ok = t + t_rp;
            m_open = 0;
        end
        if (!m_open) begin
            t = gate(max2(now, act_ok));
            push(K_ACT, t, ra, 0, 0, 0);
            m_open = 1; m_row = ra;
            col_ok = t + t_rcd;
            pre_ok = t + t_ras;
        end
        t = gate(max2(now, col_ok));
        push(wr ? K_WR : K_RD, t, ra, ca, id, len);
        pre_ok = max2(pre_ok, t + (wr ? t_wr : t_rtp));
    endtask

    task automatic model_ref(int r);
        int t;
        if (m_open) begin
            t = gate(max2(r, pre_ok));
            push(K_PRE, t, m_row, 0, 0, 0);
            act_ok = t + t_rp;
            m_open = 0;
        end
        t = gate(max2(r, act_ok));
        push(K_REF, t, 0, 0, 0, 0);
        push(K_DONE, t + t_rfc, 0, 0, 0, 0);
        act_ok = t + t_rfc;
    endtask

    task automatic chk(string name, int act, int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic check_evt(int kind);
        exp_t e;
        bit ok;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event cyc=%0d got_kind=%0d required=none", cyc, kind);
            return;
        end
        e = q.pop_front();
        ok = e.kind == kind && e.cyc == cyc;
        if (kind != K_DONE)
            ok = ok && int'(bk_req.ba) == BK;
        if (kind == K_ACT || kind == K_PRE || kind == K_RD || kind == K_WR)
            ok = ok && int'(bk_req.ra) == e.ra;
        if (kind == K_RD || kind == K_WR)
            ok = ok && int'(bk_req.ca) == e.ca && int'(bk_req.id) == e.id && int'(bk_req.len) == e.len;
        if (!ok) begin
            n_fail++;
            $display("FAIL event got kind=%0d cyc=%0d ra=%0d ca=%0d id=%0d len=%0d required kind=%0d cyc=%0d ra=%0d ca=%0d id=%0d len=%0d",
                     kind, cyc, bk_req.ra, bk_req.ca, bk_req.id, bk_req.len,
                     e.kind, e.cyc, e.ra, e.ca, e.id, e.len);
        end
    endtask

    // monitor: checks every granted request and every ref_done pulse against the queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_bits != '0)
                chk("req_onehot", $countones(req_bits), 1);
            if (hold) begin
                if (cyc == hold_lo)
                    snap = bk_req;
                else
                    chk("held_req_stable", int'(bk_req !== snap), 0);
            end
            if (ref_done_o)
                check_evt(K_DONE);
            if (bk_gnt != '0)
                check_evt(bk_gnt.act_gnt ? K_ACT : bk_gnt.rd_gnt ? K_RD : bk_gnt.wr_gnt ? K_WR :
                          bk_gnt.pre_gnt ? K_PRE : K_REF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_timing(int rcd, int ras, int rtp, int wr, int rp, int rfc);
        t_rcd = rcd; t_ras = ras; t_rtp = rtp; t_wr = wr; t_rp = rp; t_rfc = rfc;
        tif.t_rcd_m1 = T_RCD_WIDTH'(rcd - 1);
        tif.t_ras_m1 = T_RAS_WIDTH'(ras - 1);
        tif.t_rtp_m1 = T_RTP_WIDTH'(rtp - 1);
        tif.t_wr_m1  = T_WR_WIDTH'(wr - 1);
        tif.t_rp_m1  = T_RP_WIDTH'(rp - 1);
        tif.t_rfc_m1 = T_RFC_WIDTH'(rfc - 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !cmd_ready) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout cyc=%0d queued=%0d required=0", cyc, q.size());
            q.delete();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!ref_done_o && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL ref_done_timeout cyc=%0d got=0 required=1", cyc);
        end
        tick();
        ref_req_i = 1'b0;
    endtask

    task automatic issue_cmd(bit wr, int ra, int ca, int id, int len, bit with_ref);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_ra    = DRAM_RA_WIDTH'(ra);
        cmd_ca    = DRAM_CA_WIDTH'(ca);
        cmd_id    = AXI_ID_WIDTH'(id);
        cmd_len   = AXI_LEN_WIDTH'(len);
        if (with_ref) begin
            ref_req_i = 1'b1;
            model_ref(cyc);
        end
        model_access(cyc + 1, wr, ra, ca, id, len);
        tick();
        cmd_valid = 1'b0;
        if (with_ref)
            wait_done();
    endtask

    task automatic run_random(int n);
        int rows[4] = '{5, 9, 2, 5};
        for (int i = 0; i < n; i++) begin
            int op;
            op = $urandom_range(0, 9);
            wait_idle();
            repeat ($urandom_range(0, 3)) tick();
            if (op < 2) begin
                ref_req_i = 1'b1;
                model_ref(cyc);
                wait_done();
            end else begin
                issue_cmd(1'($urandom_range(0, 1)), rows[$urandom_range(0, 3)], $urandom_range(0, 1023),
                          $urandom_range(0, 15), $urandom_range(0, 255), op == 2);
            end
        end
    endtask

    initial begin
        int n;
        set_timing(3, 6, 2, 5, 3, 10);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_req_bits", int'(req_bits), 0);
        chk("reset_ref_done", int'(ref_done_o), 0);
        rst_n = 1'b1;
        tick();

        issue_cmd(0, 5, 17, 3, 7, 0);
        wait_idle();
        issue_cmd(0, 5, 40, 4, 1, 0);
        wait_idle();
        issue_cmd(1, 5, 12, 5, 2, 0);
        wait_idle();
        issue_cmd(0, 9, 99, 6, 3, 0);
        wait_idle();
        issue_cmd(0, 9, 77, 7, 0, 1);
        run_random(60);

        wait_idle();
        repeat (10) tick();
        hold_lo = cyc + 1;
        hold_hi = cyc + 4;
        issue_cmd(0, m_row == 5 ? 9 : 5, 33, 8, 4, 0);
        wait_idle();
        hold_lo = -10;
        hold_hi = -10;

        issue_cmd(1, m_row == 5 ? 2 : 5, 21, 9, 5, 0);
        n = 0;
        while (!(q.size() > 0 && q[0].kind == K_WR) && n < 50) begin
            tick();
            n++;
        end
        chk("reach_activating", int'(n < 50), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_cmd_ready", int'(cmd_ready), 1);
        chk("midreset_req_bits", int'(req_bits), 0);
        chk("midreset_ref_done", int'(ref_done_o), 0);
        q.delete();
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("post_reset_idle_bits", int'(req_bits), 0);
        chk("post_reset_cmd_ready", int'(cmd_ready), 1);

        set_timing(1, 1, 1, 1, 1, 1);
        issue_cmd(0, 3, 5, 1, 0, 0);
        run_random(40);
        wait_idle();
        chk("final_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sal_bk_ctrl.md
# sal_bk_ctrl

Per-bank DRAM controller: the requester side of the bank-controller/scheduler handshake. It accepts one access at a time from the address decoder, tracks the bank's open row and intra-bank timing (tRCD, tRAS, tRTP, tWR, tRP, tRFC), and raises exactly one of act/rd/wr/pre/ref request toward the round-robin scheduler. It advances its state only on the matching grant. One instance exists per bank; `bk_cnt` instances feed the scheduler's request array.

## Interface
- `BK_ID`, 0: bank index; drives the `ba` field of every request.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `timing_if` TIMING_IF.MON: `t_rcd_m1`, `t_ras_m1`, `t_rtp_m1`, `t_wr_m1`, `t_rp_m1`, `t_rfc_m1`.
- `cmd_valid` in 1: decoder access valid.
- `cmd_ready` out 1: single-entry buffer empty.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_ra` in `DRAM_RA_WIDTH`: row address.
- `cmd_ca` in `DRAM_CA_WIDTH`: column address.
- `cmd_id` in `AXI_ID_WIDTH`: transaction ID.
- `cmd_len` in `AXI_LEN_WIDTH`: burst length.
- `ref_req_i` in 1: refresh request, level; held until `ref_done_o`.
- `ref_done_o` out 1: one-cycle pulse when tRFC expires.
- `bk_req` out `bk_req_t`: `act_req/rd_req/wr_req/pre_req/ref_req`, plus `ba/ra/ca/id/len`.
- `bk_gnt` in `bk_gnt_t`: `act_gnt/rd_gnt/wr_gnt/pre_gnt/ref_gnt`.

## Operation
- Buffer:
  - `cmd_ready = ~pend_q`. Accept on `cmd_valid & cmd_ready`.
  - Cleared on `rd_gnt | wr_gnt`. The next accept is possible the following cycle.
- States:
  - CLOSED: if `ref_req_i`, assert `ref_req`. Otherwise, if `pend_q`, assert `act_req` with `ra = pend ra`.
  - CLOSED on `ref_gnt`: go to REFRESHING and load `rfc_cnt`.
  - CLOSED on `act_gnt`: go to ACTIVATING, load `rcd_cnt` and `ras_cnt`, and set `open_row`.
  - ACTIVATING: go to OPEN when `rcd_cnt == 0`. No request is raised.
  - OPEN, row hit, no refresh pending: assert `rd_req` or `wr_req` with the pending ra/ca/id/len.
  - OPEN on `rd_gnt`: load `rtp_cnt`.
  - OPEN on `wr_gnt`: load `wr_cnt`.
  - OPEN, row miss or `ref_req_i`: assert `pre_req` only when `ras_cnt`, `rtp_cnt` and `wr_cnt` are all 0. `ra` = `open_row`.
  - OPEN on `pre_gnt`: go to PRECHARGING and load `rp_cnt`.
  - OPEN, idle (no pending access, no refresh): the row stays open (open-page policy).
  - PRECHARGING: go to CLOSED when `rp_cnt == 0`.
  - REFRESHING: go to CLOSED when `rfc_cnt == 0`, pulsing `ref_done_o` in that cycle.
- Priority: refresh beats a pending access in both CLOSED and OPEN. A row hit is served before a conflict precharge, except when refresh is pending.
- Request bits are combinational from state, counters and the buffer. At most one bit is high per cycle.
- Grants:
  - A grant bit whose request bit is low is ignored; the bench asserts it never happens.
  - The grant is consumed in the same cycle it is seen.
- Counters:
  - Each loads `*_m1` on its trigger grant and decrements to 0, saturating there.
  - Widths are `T_*_WIDTH`.

## Timing
- Reset values:
  - state CLOSED; all counters 0; `pend_q = 0`; `open_row = 0`.
  - `cmd_ready = 1`; all `bk_req` bits 0; `ref_done_o = 0`.
- Latency: with ACT granted at cycle 0, rd/wr_req is first asserted at cycle tRCD.
- Latency: with PRE granted at cycle 0, act_req is first asserted at cycle tRP.
- Latency: with REF granted at cycle 0, `ref_done_o` pulses at cycle tRFC and the next request can be asserted that same cycle.
- tRAS is measured ACT→PRE. tRTP is measured RD→PRE. tWR is measured WR→PRE; `t_wr_m1` already includes write latency plus burst.
- Access latency when the buffer is empty with row hit in OPEN: `cmd_valid` at cycle 0 gives `rd_req` at cycle 1.
- `ref_req_i` rising while the buffer holds a row hit: refresh wins, and PRE waits for its timers.
- Reset asserted mid-operation (any state): immediately enter the reset values above. A pending access is dropped.
- An `*_m1` value of 0 means a 1-cycle wait.

## Structure
- Shared package `sal_pkg`:
  - `bk_state_e` {CLOSED, ACTIVATING, OPEN, PRECHARGING, REFRESHING}.
  - Existing `bk_req_t` and `bk_gnt_t`.
  - Width macros from `SAL_DDR_PARAMS.svh`.
- Sub-module `sal_dn_cnt #(W)`: load/decrement/saturate counter with `is_zero` output. One instance per timer (rcd, ras, rtp, wr, rp, rfc).

## Test plan
- Timing setup for all scenarios: tRCD=3, tRAS=6, tRTP=2, tWR=5, tRP=3, tRFC=10. The scheduler model grants every request the same cycle.
- Read, closed bank, ra=5: ACT@0 → RD@3 with ca/id/len echoed → `cmd_ready=1`@4.
- Second read, ra=5, at cycle 5: `rd_req`@6. No ACT or PRE is issued.
- Write ra=5, then read ra=9 while the bank is open: PRE held until ACT+6 and WR+5 are both satisfied → ACT(ra=9) 3 cycles after PRE → RD 3 cycles later.
- `ref_req_i` with row open and tRAS satisfied: PRE → REF 3 cycles later → `ref_done_o` 10 cycles after REF. A pending read is held until `ref_done_o`, then ACT.
- Grant withheld by the scheduler for 4 cycles: the request stays stable (same bits and fields) and the state does not change.
- `rst_n` low during ACTIVATING with a pending access: all outputs are at reset values and `cmd_ready=1` the same cycle. After release, the bank issues nothing until a new `cmd_valid`.
